// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_capture
// Description : Receive side of a multiplexed seven-segment display bus.
//               Synchronises the segment lines and one-hot digit strobes,
//               waits for the bus to hold still for STABLE_CYCLES clocks,
//               then decodes the segment pattern into a hex nibble for the
//               strobed digit. Undecodable patterns set a per-digit error
//               flag. A one-cycle pulse marks each complete frame, meaning
//               every digit has been captured since the previous pulse.
//
//               Optional feature macro: SEVEN_SEGMENT_CAPTURE_BLANK_EN
//               When defined, an all-off segment pattern is treated as a
//               blanked digit rather than an error, and the blank port is
//               present.
//
// Ports       : clk          system clock
//               rst_n        asynchronous active-low reset
//               seg_in       segments {g,f,e,d,c,b,a}, bit0 = a (async)
//               dig_in       digit strobes, one-hot when valid (async)
//               value        captured nibbles, digit i at [4i+3:4i]
//               digit_err    last capture of digit i was undecodable
//               frame_valid  1-cycle pulse when all digits have been captured
//               blank        digit i was last seen blanked (macro only)
//
// Revision    : 1.0  initial release
// ============================================================================
module seven_segment_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_in,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank
`endif
);

    localparam int                 C_WORD_W   = NUM_DIGITS + 7;
    localparam int                 C_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(STABLE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_FIRE = C_CNT_W'(STABLE_CYCLES - 1);

    // Segment pattern -> {valid, nibble}
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_decode = {1'b1, 4'h0};
            7'h06:   seg_decode = {1'b1, 4'h1};
            7'h5B:   seg_decode = {1'b1, 4'h2};
            7'h4F:   seg_decode = {1'b1, 4'h3};
            7'h66:   seg_decode = {1'b1, 4'h4};
            7'h6D:   seg_decode = {1'b1, 4'h5};
            7'h7D:   seg_decode = {1'b1, 4'h6};
            7'h07:   seg_decode = {1'b1, 4'h7};
            7'h7F:   seg_decode = {1'b1, 4'h8};
            7'h6F:   seg_decode = {1'b1, 4'h9};
            7'h77:   seg_decode = {1'b1, 4'hA};
            7'h7C:   seg_decode = {1'b1, 4'hB};
            7'h39:   seg_decode = {1'b1, 4'hC};
            7'h5E:   seg_decode = {1'b1, 4'hD};
            7'h79:   seg_decode = {1'b1, 4'hE};
            7'h71:   seg_decode = {1'b1, 4'hF};
            default: seg_decode = 5'h00;
        endcase
    endfunction

    // Pin polarity normalisation happens before the synchroniser so that
    // everything downstream sees active-high levels.
    logic [C_WORD_W-1:0] w_word_pin;

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign w_word_pin = ~{dig_in, seg_in};
        end else begin : g_active_high
            assign w_word_pin = {dig_in, seg_in};
        end
    endgenerate

    logic [C_WORD_W-1:0]     sync1_q;
    logic [C_WORD_W-1:0]     word_s_q;
    logic [C_WORD_W-1:0]     word_d_q;
    logic [C_CNT_W-1:0]      cnt_q,         cnt_d;
    logic [4*NUM_DIGITS-1:0] value_q,       value_d;
    logic [NUM_DIGITS-1:0]   digit_err_q,   digit_err_d;
    logic [NUM_DIGITS-1:0]   seen_q,        seen_d;
    logic                    frame_valid_q, frame_valid_d;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
    logic [NUM_DIGITS-1:0]   blank_q,       blank_d;
`endif

    logic                  w_capture;
    logic [NUM_DIGITS-1:0] w_dig;
    logic [6:0]            w_seg;
    logic [4:0]            w_dec;

    assign w_dig = word_s_q[C_WORD_W-1:7];
    assign w_seg = word_s_q[6:0];
    assign w_dec = seg_decode(w_seg);

    // The counter saturates at STABLE_CYCLES, one past the firing value,
    // so a held pattern fires exactly once.
    assign w_capture = (word_s_q == word_d_q) && (cnt_q == C_CNT_FIRE);

    always_comb begin
        cnt_d         = cnt_q;
        value_d       = value_q;
        digit_err_d   = digit_err_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
        blank_d       = blank_q;
`endif

        if (word_s_q != word_d_q) begin
            cnt_d = '0;
        end else if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end

        // Captures with no strobe or several strobes carry no digit identity
        // and are dropped entirely.
        if (w_capture && $onehot(w_dig)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_dig[i]) begin
                    if (w_dec[4]) begin
                        value_d[4*i +: 4] = w_dec[3:0];
                        digit_err_d[i]    = 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
                        blank_d[i]        = 1'b0;
                    end else if (w_seg == 7'h00) begin
                        blank_d[i]        = 1'b1;
                        digit_err_d[i]    = 1'b0;
`endif
                    end else begin
                        digit_err_d[i]    = 1'b1;
                    end
                end
            end

            seen_d = seen_q | w_dig;
            if (&seen_d) begin
                frame_valid_d = 1'b1;
                seen_d        = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            word_s_q      <= '0;
            word_d_q      <= '0;
            cnt_q         <= '0;
            value_q       <= '0;
            digit_err_q   <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
            blank_q       <= '0;
`endif
        end else begin
            sync1_q       <= w_word_pin;
            word_s_q      <= sync1_q;
            word_d_q      <= word_s_q;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
            blank_q       <= blank_d;
`endif
        end
    end

    assign value       = value_q;
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
    assign blank       = blank_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_capture
// Description : Self-checking bench for seven_segment_capture with
//               NUM_DIGITS=4, STABLE_CYCLES=8, active-high pins. Each applied
//               pattern pushes its expected post-capture state onto a
//               scoreboard queue; the entry is popped and compared on the
//               capture edge (edge STABLE_CYCLES+3 after the pins change).
// Revision    : 1.0  initial release
// ============================================================================
module tb_seven_segment_capture;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int C_CAP_EDGE    = STABLE_CYCLES + 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_in = '0;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
    logic [3:0]  blank;
`endif

    seven_segment_capture #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .ACTIVE_LOW    (0)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_in      (dig_in),
        .value       (value),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
        ,
        .blank       (blank)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  err;
        logic [3:0]  blank;
        logic [3:0]  seen;
        logic        frame;
    } exp_t;

    exp_t sb[$];

    logic [6:0] c_seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                   7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                   7'h39, 7'h5E, 7'h79, 7'h71};

    // Model of what the DUT currently shows
    logic [15:0] m_value = '0;
    logic [3:0]  m_err   = '0;
    logic [3:0]  m_blank = '0;
    logic [3:0]  m_seen  = '0;

    int    n_cmp = 0;
    int    n_bad = 0;
    string step  = "init";

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL [%s] %s: got %0h expected %0h", step, tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input logic [3:0] dig, input logic [6:0] seg);
        exp_t e;
        int   idx;
        e.value = m_value;
        e.err   = m_err;
        e.blank = m_blank;
        e.seen  = m_seen;
        e.frame = 1'b0;
        if (dig == 4'b0001 || dig == 4'b0010 || dig == 4'b0100 || dig == 4'b1000) begin
            idx = -1;
            for (int n = 0; n < 16; n++) begin
                if (c_seg_tab[n] == seg) idx = n;
            end
            for (int i = 0; i < 4; i++) begin
                if (dig[i]) begin
                    if (idx >= 0) begin
                        e.value[4*i +: 4] = 4'(idx);
                        e.err[i]          = 1'b0;
                        e.blank[i]        = 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
                    end else if (seg == 7'h00) begin
                        e.blank[i]        = 1'b1;
                        e.err[i]          = 1'b0;
`endif
                    end else begin
                        e.err[i]          = 1'b1;
                    end
                end
            end
            e.seen = m_seen | dig;
            if (e.seen == 4'hF) begin
                e.frame = 1'b1;
                e.seen  = 4'h0;
            end
        end
        return e;
    endfunction

    // Walks 'hold' clock edges from the moment the pins changed (just after a
    // negedge). Outputs must be unchanged through edge STABLE_CYCLES+2 and
    // match the scoreboard entry on edge STABLE_CYCLES+3.
    task automatic wait_capture(input int hold);
        exp_t e;
        for (int c = 1; c <= hold; c++) begin
            @(posedge clk);
            #1;
            if (c == C_CAP_EDGE) begin
                check_eq("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("value", 32'(value), 32'(e.value));
                    check_eq("digit_err", 32'(digit_err), 32'(e.err));
                    check_eq("frame_valid", 32'(frame_valid), 32'(e.frame));
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
                    check_eq("blank", 32'(blank), 32'(e.blank));
`endif
                    m_value = e.value;
                    m_err   = e.err;
                    m_blank = e.blank;
                    m_seen  = e.seen;
                end
            end else begin
                check_eq("frame_idle", 32'(frame_valid), 32'd0);
                if (c == C_CAP_EDGE - 1) begin
                    check_eq("value_early", 32'(value), 32'(m_value));
                    check_eq("err_early", 32'(digit_err), 32'(m_err));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic apply(input logic [3:0] dig, input logic [6:0] seg, input int hold);
        dig_in = dig;
        seg_in = seg;
        sb.push_back(predict(dig, seg));
        wait_capture(hold);
    endtask

    task automatic glitch(input logic [6:0] seg, input int len);
        seg_in = seg;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            check_eq("glitch_value", 32'(value), 32'(m_value));
            check_eq("glitch_frame", 32'(frame_valid), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        step = "reset";
        repeat (3) @(negedge clk);
        check_eq("rst_value", 32'(value), 32'd0);
        check_eq("rst_err", 32'(digit_err), 32'd0);
        check_eq("rst_frame", 32'(frame_valid), 32'd0);
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
        check_eq("rst_blank", 32'(blank), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        // Decode of four digits, frame on the last
        step = "decode";
        apply(4'b0001, 7'h5B, 20);
        apply(4'b0010, 7'h66, 20);
        apply(4'b0100, 7'h7C, 20);
        apply(4'b1000, 7'h71, 20);
        check_eq("frame_word", 32'(value), 32'h0000_FB42);

        // Latency of a plain change, then a short glitch and recovery
        step = "latency";
        apply(4'b0001, 7'h06, 20);
        glitch(7'h4F, 5);
        apply(4'b0001, 7'h06, 20);
        check_eq("after_glitch", 32'(value), 32'h0000_FB41);

        // Undecodable pattern, then recovery
        step = "error";
        apply(4'b0001, 7'h7E, 20);
        check_eq("err_set", 32'(digit_err), 32'h1);
        apply(4'b0001, 7'h06, 20);
        check_eq("err_clr", 32'(digit_err), 32'h0);

        // No strobe and multi-hot strobe are ignored
        step = "illegal";
        apply(4'b0000, 7'h3F, 50);
        apply(4'b0011, 7'h06, 50);

        // All-off segments
        step = "blank";
        apply(4'b0100, 7'h00, 20);
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
        check_eq("blank_bit", 32'(blank), 32'h4);
        check_eq("blank_noerr", 32'(digit_err), 32'h0);
`else
        check_eq("blank_err", 32'(digit_err), 32'h4);
`endif

        // Remaining digits complete a second frame
        step = "frame2";
        apply(4'b0010, 7'h5E, 20);
        apply(4'b1000, 7'h39, 20);
        check_eq("frame2_word", 32'(value), 32'h0000_CBD1);

        // Asynchronous reset in the middle of a stable count
        step = "midreset";
        dig_in = 4'b0001;
        seg_in = 7'h4F;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_value", 32'(value), 32'd0);
        check_eq("mid_err", 32'(digit_err), 32'd0);
        check_eq("mid_frame", 32'(frame_valid), 32'd0);
        m_value = '0;
        m_err   = '0;
        m_blank = '0;
        m_seen  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(predict(4'b0001, 7'h4F));
        wait_capture(20);
        check_eq("post_rst_value", 32'(value), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
